// File: rtl/cpu_trace_pkg.sv
// Shared types and helpers for the CPU instruction-trace buffer.
// Contents: capture state enum, opcode field width, record width helper.
package cpu_trace_pkg;

  localparam int unsigned OPCODE_W = 6;

  typedef enum logic [1:0] {
    TR_IDLE    = 2'd0,
    TR_CAPTURE = 2'd1,
    TR_DONE    = 2'd2
  } tr_state_e;

  // Width of one stored {pc, instr} record.
  function automatic int unsigned rec_width(input int unsigned pc_w, input int unsigned instr_w);
    return pc_w + instr_w;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: one synchronous write port, one
// asynchronous read port. Contents are not reset.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (combinational read).
module trace_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Asynchronous read port.
  assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_trace_buffer.sv
// Instruction-trace capture buffer for the single-cycle CPU.
// Records {pc, instr} per retired cycle into a circular buffer in one-shot
// (first N samples) or ring (last N samples until stop) mode, then drains
// the records oldest-first over a valid/ready port.
// Optional build macro TRACE_OPCODE_FILTER_EN adds filt_op/filt_mask inputs
// (sampled on arm) that restrict capture to matching opcodes.
// Ports:
//   clk, reset (async, active-low)
//   pc, instr, sample_en           retired-instruction sample
//   arm, mode, limit, stop         capture control
//   rd_valid, rd_data, rd_ready    drain port
//   count, busy, overflow          status
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int unsigned PC_W    = 32,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned DEPTH   = 64,
  localparam int unsigned AW     = $clog2(DEPTH),
  localparam int unsigned CW     = AW + 1,
  localparam int unsigned RW     = rec_width(PC_W, INSTR_W)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PC_W-1:0]     pc,
  input  logic [INSTR_W-1:0]  instr,
  input  logic                sample_en,
  input  logic                arm,
  input  logic                mode,
  input  logic [CW-1:0]       limit,
  input  logic                stop,
`ifdef TRACE_OPCODE_FILTER_EN
  input  logic [OPCODE_W-1:0] filt_op,
  input  logic [OPCODE_W-1:0] filt_mask,
`endif
  output logic                rd_valid,
  output logic [RW-1:0]       rd_data,
  input  logic                rd_ready,
  output logic [CW-1:0]       count,
  output logic                busy,
  output logic                overflow
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  tr_state_e     state, state_n;
  logic [AW-1:0] wr_ptr, wr_ptr_n;
  logic [AW-1:0] rd_ptr, rd_ptr_n;
  logic [CW-1:0] count_n;
  logic [CW-1:0] lim_q, lim_n;
  logic          mode_q, mode_n;
  logic          overflow_n;
  logic          rd_valid_n;
  logic          busy_n;
  logic          wr_en;
  logic          hit;

`ifdef TRACE_OPCODE_FILTER_EN
  logic [OPCODE_W-1:0] fop_q, fop_n;
  logic [OPCODE_W-1:0] fmask_q, fmask_n;

  // Masked opcode compare; a zero mask accepts everything.
  assign hit = ((instr[INSTR_W-1 -: OPCODE_W] ^ fop_q) & fmask_q) == '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fop_q   <= '0;
      fmask_q <= '0;
    end else begin
      fop_q   <= fop_n;
      fmask_q <= fmask_n;
    end
  end
`else
  assign hit = 1'b1;
`endif

  // State, pointer and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= TR_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      lim_q    <= DEPTH_C;
      mode_q   <= 1'b0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      count    <= count_n;
      lim_q    <= lim_n;
      mode_q   <= mode_n;
      overflow <= overflow_n;
      rd_valid <= rd_valid_n;
      busy     <= busy_n;
    end
  end

  // Next-state, pointer and write-enable logic.
  always_comb begin
    state_n    = state;
    wr_ptr_n   = wr_ptr;
    rd_ptr_n   = rd_ptr;
    count_n    = count;
    lim_n      = lim_q;
    mode_n     = mode_q;
    overflow_n = overflow;
    wr_en      = 1'b0;
`ifdef TRACE_OPCODE_FILTER_EN
    fop_n      = fop_q;
    fmask_n    = fmask_q;
`endif

    if (arm) begin
      // Arm restarts from any state and overrides stop/sample_en.
      state_n    = TR_CAPTURE;
      wr_ptr_n   = '0;
      rd_ptr_n   = '0;
      count_n    = '0;
      overflow_n = 1'b0;
      mode_n     = mode;
      lim_n      = (limit == '0 || limit > DEPTH_C) ? DEPTH_C : limit;
`ifdef TRACE_OPCODE_FILTER_EN
      fop_n      = filt_op;
      fmask_n    = filt_mask;
`endif
    end else begin
      unique case (state)
        TR_CAPTURE: begin
          if (sample_en && hit) begin
            wr_en    = 1'b1;
            wr_ptr_n = wr_ptr + AW'(1);
            if (mode_q && count == DEPTH_C) begin
              // Ring full: overwrite the oldest entry.
              rd_ptr_n   = rd_ptr + AW'(1);
              overflow_n = 1'b1;
            end else begin
              count_n = count + CW'(1);
            end
            if (!mode_q && (count + CW'(1)) == lim_q) state_n = TR_DONE;
          end
          if (stop) state_n = TR_DONE;
        end
        TR_DONE: begin
          if (count == '0) begin
            state_n = TR_IDLE;
          end else if (rd_valid && rd_ready) begin
            rd_ptr_n = rd_ptr + AW'(1);
            count_n  = count - CW'(1);
            if (count == CW'(1)) state_n = TR_IDLE;
          end
        end
        default: state_n = TR_IDLE;
      endcase
    end

    rd_valid_n = (state_n == TR_DONE) && (count_n != '0);
    busy_n     = (state_n == TR_CAPTURE);
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (RW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata ({pc, instr}),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

endmodule
